// File: rtl/seg_serializer_if.sv
// seg_serializer_if: groups the display-path handshake and output lanes.
// The master side drives the BCD value, decimal points and trigger. The
// slave side (the serializer) drives the serial lanes and the status.
interface seg_serializer_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] cnt_in;
  logic [DIGITS-1:0]   dp_in;
  logic                trigger;
  logic [DIGITS-1:0]   seg_data;
  logic                shift_clk;
  logic                latch;
  logic                busy;

  modport master (
    output cnt_in, dp_in, trigger,
    input  seg_data, shift_clk, latch, busy
  );

  modport slave (
    input  cnt_in, dp_in, trigger,
    output seg_data, shift_clk, latch, busy
  );
endinterface

// File: rtl/seg_serializer.sv
// seg_serializer: 7-segment decode and serialise engine for the counter display.
// A trigger snapshots DIGITS BCD nibbles plus their decimal points. One digit
// is decoded per cycle. The segment words are then shifted MSB first on DIGITS
// parallel lanes, using a divided shift clock, and a latch strobe follows the
// last bit. A trigger that arrives while busy is held in a one-deep pending flag.
//
// Optional build macro SEGSER_LZ_BLANK_EN: leading-zero blanking. When it is
// defined, digits above the most significant non-zero digit have a..g cleared,
// and their dp still follows dp_in. Digit 0 is never blanked. Frame timing is
// the same in both builds.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for trigger or pending; captures cnt_in/dp_in on start
// S_DECODE | one digit per cycle, d=0 upward, into an 8-bit segment word
// S_SHIFT  | SEG_BITS bits per lane, shift_clk low/high for CLK_DIV cycles each
// S_LATCH  | one-cycle latch strobe, lanes and shift_clk forced low
module seg_serializer #(
  parameter int DIGITS   = 6,
  parameter int SEG_BITS = 8,
  parameter int CLK_DIV  = 1
) (
  input  logic             clk,
  input  logic             reset,
  seg_serializer_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW-1:0] DEC_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PH_LOAD  = PW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LOAD = 3'(SEG_BITS - 1);
  localparam logic          DP_EN    = (SEG_BITS == 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] snap_cnt_q, snap_cnt_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [7:0]          word_q [DIGITS];
  logic [7:0]          word_d [DIGITS];
  logic                pend_q, pend_d;
  logic [IW-1:0]       dec_tmr_q, dec_tmr_d;
  logic [PW-1:0]       ph_tmr_q, ph_tmr_d;
  logic [2:0]          bit_q, bit_d;
  logic [DIGITS-1:0]   seg_data_q, seg_data_d;
  logic                shift_clk_q, shift_clk_d;
  logic                latch_q, latch_d;
  logic                busy_q, busy_d;

  logic [DIGITS-1:0]   lz_blank;
  logic [IW-1:0]       dec_idx;
  logic [3:0]          dec_nib;
  logic                dec_dp;
  logic                dec_blank;
  logic [7:0]          dec_word;

  // Standard glyphs for 0-9; any non-BCD value shows a dash.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

`ifdef SEGSER_LZ_BLANK_EN
  logic zero_run;

  // Mark each digit whose own nibble and all nibbles above it are zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_run    = zero_run & (snap_cnt_q[4*d +: 4] == 4'h0);
      lz_blank[d] = zero_run;
    end
  end
`else
  // Without blanking, every digit decodes normally.
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Select the digit that the decode timer points at and build its segment word.
  always_comb begin
    dec_idx   = DEC_LAST - dec_tmr_q;
    dec_nib   = 4'h0;
    dec_dp    = 1'b0;
    dec_blank = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dec_idx == IW'(d)) begin
        dec_nib   = snap_cnt_q[4*d +: 4];
        dec_dp    = snap_dp_q[d];
        dec_blank = lz_blank[d];
      end
    end
    dec_word = {dec_dp & DP_EN, dec_blank ? 7'h00 : seg7(dec_nib)};
  end

  // Next-state logic for the FSM, the timers and the registered outputs.
  always_comb begin
    state_d     = state_q;
    snap_cnt_d  = snap_cnt_q;
    snap_dp_d   = snap_dp_q;
    for (int d = 0; d < DIGITS; d++) begin
      word_d[d] = word_q[d];
    end
    pend_d      = pend_q;
    dec_tmr_d   = dec_tmr_q;
    ph_tmr_d    = ph_tmr_q;
    bit_d       = bit_q;
    seg_data_d  = seg_data_q;
    shift_clk_d = shift_clk_q;
    latch_d     = 1'b0;

    // A request while busy, including the latch cycle, collapses into one pending start.
    if ((state_q != S_IDLE) && bus.trigger) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.trigger || pend_q) begin
          snap_cnt_d = bus.cnt_in;
          snap_dp_d  = bus.dp_in;
          pend_d     = 1'b0;
          dec_tmr_d  = DEC_LAST;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        for (int d = 0; d < DIGITS; d++) begin
          if (dec_idx == IW'(d)) begin
            word_d[d] = dec_word;
          end
        end
        if (dec_tmr_q == '0) begin
          // The last digit's word is written this same cycle, so the first bit comes from word_d.
          state_d     = S_SHIFT;
          bit_d       = BIT_LOAD;
          ph_tmr_d    = PH_LOAD;
          shift_clk_d = 1'b0;
          for (int d = 0; d < DIGITS; d++) begin
            seg_data_d[d] = word_d[d][BIT_LOAD];
          end
        end else begin
          dec_tmr_d = dec_tmr_q - 1'b1;
        end
      end

      S_SHIFT: begin
        if (ph_tmr_q != '0) begin
          ph_tmr_d = ph_tmr_q - 1'b1;
        end else begin
          ph_tmr_d = PH_LOAD;
          if (!shift_clk_q) begin
            shift_clk_d = 1'b1;
          end else if (bit_q == '0) begin
            state_d     = S_LATCH;
            shift_clk_d = 1'b0;
            seg_data_d  = '0;
            latch_d     = 1'b1;
          end else begin
            // Data moves only as shift_clk falls, so it is stable across every rising edge.
            bit_d       = bit_q - 3'd1;
            shift_clk_d = 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
              seg_data_d[d] = word_q[d][bit_q - 3'd1];
            end
          end
        end
      end

      S_LATCH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame without a latch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      snap_cnt_q  <= '0;
      snap_dp_q   <= '0;
      for (int d = 0; d < DIGITS; d++) begin
        word_q[d] <= '0;
      end
      pend_q      <= 1'b0;
      dec_tmr_q   <= '0;
      ph_tmr_q    <= '0;
      bit_q       <= '0;
      seg_data_q  <= '0;
      shift_clk_q <= 1'b0;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_cnt_q  <= snap_cnt_d;
      snap_dp_q   <= snap_dp_d;
      for (int d = 0; d < DIGITS; d++) begin
        word_q[d] <= word_d[d];
      end
      pend_q      <= pend_d;
      dec_tmr_q   <= dec_tmr_d;
      ph_tmr_q    <= ph_tmr_d;
      bit_q       <= bit_d;
      seg_data_q  <= seg_data_d;
      shift_clk_q <= shift_clk_d;
      latch_q     <= latch_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.seg_data  = seg_data_q;
  assign bus.shift_clk = shift_clk_q;
  assign bus.latch     = latch_q;
  assign bus.busy      = busy_q;

endmodule
